// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam logic [63:0] PC_STEP = 64'd4;

  // Word-aligned when the two low address bits are clear.
  function automatic logic is_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage bus: hazard/branch inputs, imem read, and IF/ID outputs.
interface fetch_if;
  import fetch_pkg::*;

  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [31:0] instr_in;
  logic [63:0] pc;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic        ifid_valid;
  logic [1:0]  fetch_state;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, instr_in,
    output pc, ifid_instr, ifid_pc, ifid_valid, fetch_state, fault, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, instr_in,
    input  pc, ifid_instr, ifid_pc, ifid_valid, fetch_state, fault, fetch_count
  );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register; flush inserts a bubble and wins over enable.
module ifid_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [63:0] pc_in,
  output logic [31:0] instr,
  output logic [63:0] pc,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr <= 32'h0;
      pc    <= 64'h0;
      valid <= 1'b0;
    end else if (enable) begin
      instr <= instr_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC sequencing, branch redirect, stall hold and
// misaligned-target fault capture feeding the IF/ID register.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic clk,
  input  logic reset,
  fetch_if.master bus
);

  logic [63:0] pc_q;
  state_e      state;
  logic        fault_q;
  logic [31:0] count_q;

  logic        in_range_c;
  logic        aligned_c;
  logic        ifid_en_c;
  logic        ifid_flush_c;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic        ifid_valid;

  assign in_range_c = pc_q < 64'(IMEM_BYTES);
  assign aligned_c  = is_aligned(bus.branch_target[1:0]);

  // IF/ID control: load only on a real fetch, bubble whenever not loading or holding.
  always_comb begin
    ifid_en_c    = 1'b0;
    ifid_flush_c = 1'b0;
    case (state)
      RUN: begin
        if (bus.branch_taken)  ifid_flush_c = 1'b1;
        else if (!bus.stall) begin
          if (in_range_c) ifid_en_c    = 1'b1;
          else            ifid_flush_c = 1'b1;
        end
      end
      default: ifid_flush_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state   <= BOOT;
      fault_q <= 1'b0;
      count_q <= 32'h0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (bus.branch_taken) begin
            if (aligned_c) begin
              pc_q <= bus.branch_target;
            end else begin
              fault_q <= 1'b1;
              state   <= FAULT;
            end
          end else if (!bus.stall) begin
            if (in_range_c) begin
              pc_q <= pc_q + PC_STEP;
              if (count_q != 32'hFFFF_FFFF) count_q <= count_q + 32'd1;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.branch_taken) begin
            if (aligned_c) begin
              pc_q  <= bus.branch_target;
              state <= RUN;
            end else begin
              fault_q <= 1'b1;
              state   <= FAULT;
            end
          end
        end
        FAULT: state <= FAULT;
        default: state <= BOOT;
      endcase
    end
  end

  ifid_reg u_ifid (
    .clk      (clk),
    .reset    (reset),
    .enable   (ifid_en_c),
    .flush    (ifid_flush_c),
    .instr_in (bus.instr_in),
    .pc_in    (pc_q),
    .instr    (ifid_instr),
    .pc       (ifid_pc),
    .valid    (ifid_valid)
  );

  assign bus.pc          = pc_q;
  assign bus.ifid_instr  = ifid_instr;
  assign bus.ifid_pc     = ifid_pc;
  assign bus.ifid_valid  = ifid_valid;
  assign bus.fetch_state = state;
  assign bus.fault       = fault_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: one instance with the default memory
// size and one with a 16-byte memory to reach the end-of-memory state.
module tb_fetch_controller;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   checks   = 0;
  int   failures = 0;

  fetch_if a_if ();
  fetch_if b_if ();

  always #5 clk = ~clk;

  // Instruction memory model: word tagged with its own address.
  assign a_if.instr_in = {16'hA5A5, a_if.pc[15:0]};
  assign b_if.instr_in = {16'h5A5A, b_if.pc[15:0]};

  fetch_controller #(.RESET_PC(64'h0), .IMEM_BYTES(1024)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (a_if.master)
  );

  fetch_controller #(.RESET_PC(64'h0), .IMEM_BYTES(16)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (b_if.master)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [63:0] pc, input logic [63:0] ipc,
                       input logic v, input logic [1:0] st, input logic [31:0] cnt);
    chk({tag, ".pc"},    a_if.pc,                 pc);
    chk({tag, ".ifpc"},  a_if.ifid_pc,            ipc);
    chk({tag, ".valid"}, 64'(a_if.ifid_valid),    64'(v));
    chk({tag, ".state"}, 64'(a_if.fetch_state),   64'(st));
    chk({tag, ".count"}, 64'(a_if.fetch_count),   64'(cnt));
  endtask

  task automatic chk_b(input string tag, input logic [63:0] pc, input logic [63:0] ipc,
                       input logic v, input logic [1:0] st);
    chk({tag, ".pc"},    b_if.pc,               pc);
    chk({tag, ".ifpc"},  b_if.ifid_pc,          ipc);
    chk({tag, ".valid"}, 64'(b_if.ifid_valid),  64'(v));
    chk({tag, ".state"}, 64'(b_if.fetch_state), 64'(st));
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    a_if.stall = 1'b0; a_if.branch_taken = 1'b0; a_if.branch_target = 64'h0;
    b_if.stall = 1'b0; b_if.branch_taken = 1'b0; b_if.branch_target = 64'h0;

    // Reset values
    step();
    chk_a("rst", 64'h0, 64'h0, 1'b0, ST_BOOT, 32'd0);
    chk("rst.instr", 64'(a_if.ifid_instr), 64'h0);
    chk("rst.fault", 64'(a_if.fault), 64'h0);

    // Straight-line fetch after reset
    reset_a = 1'b0;
    step(); chk_a("boot",  64'd0,  64'd0, 1'b0, ST_RUN, 32'd0);
    step(); chk_a("f0",    64'd4,  64'd0, 1'b1, ST_RUN, 32'd1);
    chk("f0.instr", 64'(a_if.ifid_instr), 64'hA5A5_0000);
    step(); chk_a("f4",    64'd8,  64'd4, 1'b1, ST_RUN, 32'd2);
    step(); chk_a("f8",    64'd12, 64'd8, 1'b1, ST_RUN, 32'd3);
    chk("f8.instr", 64'(a_if.ifid_instr), 64'hA5A5_0008);

    // Stall for three cycles at pc=8
    reset_a = 1'b1; step();
    reset_a = 1'b0; step(); step(); step();
    chk_a("pre_stall", 64'd8, 64'd4, 1'b1, ST_RUN, 32'd2);
    a_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a("stall", 64'd8, 64'd4, 1'b1, ST_RUN, 32'd2);
    end

    // Branch beats stall in the same cycle
    a_if.branch_taken = 1'b1; a_if.branch_target = 64'h40;
    step(); chk_a("br_stall", 64'h40, 64'h0, 1'b0, ST_RUN, 32'd2);
    a_if.branch_taken = 1'b0; a_if.stall = 1'b0;
    step(); chk_a("br_tgt", 64'h44, 64'h40, 1'b1, ST_RUN, 32'd3);
    chk("br_tgt.instr", 64'(a_if.ifid_instr), 64'hA5A5_0040);

    // Reset mid-stream at pc=0x20 overrides stall and branch
    a_if.branch_taken = 1'b1; a_if.branch_target = 64'h20;
    step(); chk("to20.pc", a_if.pc, 64'h20);
    a_if.stall = 1'b1; a_if.branch_target = 64'h80;
    reset_a = 1'b1;
    step();
    chk_a("mid_rst", 64'h0, 64'h0, 1'b0, ST_BOOT, 32'd0);
    chk("mid_rst.instr", 64'(a_if.ifid_instr), 64'h0);
    chk("mid_rst.fault", 64'(a_if.fault), 64'h0);

    // Misaligned branch target -> sticky fault
    reset_a = 1'b0; a_if.stall = 1'b0; a_if.branch_taken = 1'b0;
    step(); chk_a("boot2", 64'h0, 64'h0, 1'b0, ST_RUN, 32'd0);
    a_if.branch_taken = 1'b1; a_if.branch_target = 64'h42;
    step(); chk_a("mis", 64'h0, 64'h0, 1'b0, ST_FAULT, 32'd0);
    chk("mis.fault", 64'(a_if.fault), 64'h1);
    a_if.branch_target = 64'h80;
    step(); chk_a("fault_hold", 64'h0, 64'h0, 1'b0, ST_FAULT, 32'd0);
    chk("fault_hold.fault", 64'(a_if.fault), 64'h1);
    reset_a = 1'b1;
    step(); chk_a("fault_rst", 64'h0, 64'h0, 1'b0, ST_BOOT, 32'd0);
    chk("fault_rst.fault", 64'(a_if.fault), 64'h0);
    reset_a = 1'b0; a_if.branch_taken = 1'b0;

    // Small memory: run to end, DONE, redirect back
    reset_b = 1'b0;
    step(); chk_b("b.boot", 64'd0, 64'd0, 1'b0, ST_RUN);
    step(); chk_b("b.f0",  64'd4,  64'd0,  1'b1, ST_RUN);
    step(); chk_b("b.f4",  64'd8,  64'd4,  1'b1, ST_RUN);
    step(); chk_b("b.f8",  64'd12, 64'd8,  1'b1, ST_RUN);
    step(); chk_b("b.f12", 64'd16, 64'd12, 1'b1, ST_RUN);
    chk("b.f12.instr", 64'(b_if.ifid_instr), 64'h5A5A_000C);
    chk("b.f12.count", 64'(b_if.fetch_count), 64'd4);
    step(); chk_b("b.done", 64'd16, 64'd0, 1'b0, ST_DONE);
    b_if.stall = 1'b1;
    step(); chk_b("b.done_stall", 64'd16, 64'd0, 1'b0, ST_DONE);
    b_if.branch_taken = 1'b1; b_if.branch_target = 64'h8;
    step(); chk_b("b.redir", 64'h8, 64'h0, 1'b0, ST_RUN);
    b_if.branch_taken = 1'b0; b_if.stall = 1'b0;
    step(); chk_b("b.f8b", 64'd12, 64'h8, 1'b1, ST_RUN);
    chk("b.f8b.count", 64'(b_if.fetch_count), 64'd5);

    // Out-of-range aligned target accepted, DONE on the next cycle
    b_if.branch_taken = 1'b1; b_if.branch_target = 64'h100;
    step(); chk_b("b.far", 64'h100, 64'h0, 1'b0, ST_RUN);
    b_if.branch_taken = 1'b0;
    step(); chk_b("b.far_done", 64'h100, 64'h0, 1'b0, ST_DONE);
    chk("b.far_done.count", 64'(b_if.fetch_count), 64'd5);

    // Misaligned branch from DONE
    b_if.branch_taken = 1'b1; b_if.branch_target = 64'h101;
    step(); chk_b("b.mis", 64'h100, 64'h0, 1'b0, ST_FAULT);
    chk("b.mis.fault", 64'(b_if.fault), 64'h1);
    b_if.branch_taken = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, 64'h0, PC value loaded on reset.
REQ-002 Parameter IMEM_BYTES, 1024, instruction memory size in bytes; PCs >= IMEM_BYTES are out of range.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit request to hold PC and IF/ID.
REQ-006 branch_taken  input  1  redirect request from a resolved branch.
REQ-007 branch_target  input  64  redirect address, valid when branch_taken=1.
REQ-008 instr_in  input  32  instruction memory read data for address pc (combinational read, same cycle).
REQ-009 pc  output  64  current fetch address, driven to instruction memory.
REQ-010 ifid_instr  output  32  IF/ID latched instruction.
REQ-011 ifid_pc  output  64  IF/ID latched PC of ifid_instr.
REQ-012 ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-013 fetch_state  output  2  encoded FSM state (see package).
REQ-014 fault  output  1  misaligned branch target captured; sticky until reset.
REQ-015 fetch_count  output  32  number of valid instructions loaded into IF/ID, saturating.

Function
REQ-016 FSM states: BOOT, RUN, DONE, FAULT.
REQ-017 BOOT: IF/ID loaded with bubble, pc held; unconditionally -> RUN next cycle (branch_taken, stall ignored).
REQ-018 RUN, branch_taken=1, branch_target[1:0]=0: pc <= branch_target, IF/ID <= bubble; stay RUN.
REQ-019 RUN, branch_taken=1, branch_target[1:0]!=0: pc held, IF/ID <= bubble, fault <= 1, -> FAULT.
REQ-020 RUN, branch_taken=0, stall=1: pc, ifid_instr, ifid_pc, ifid_valid all held.
REQ-021 RUN, branch_taken=0, stall=0, pc < IMEM_BYTES: IF/ID <= {instr_in, pc, valid=1}; pc <= pc+4 (64-bit, wraps modulo 2^64).
REQ-022 RUN with pc >= IMEM_BYTES and no branch: IF/ID <= bubble, pc held, -> DONE.
REQ-023 branch_taken has priority over stall in every state that honours branches.
REQ-024 DONE: IF/ID bubble, pc held; aligned branch_taken redirects pc and -> RUN; misaligned -> FAULT; stall ignored.
REQ-025 FAULT: pc and IF/ID bubble held, fault=1; all inputs ignored until reset.
REQ-026 Branch target >= IMEM_BYTES accepted like any aligned target; DONE entered on the following cycle.
REQ-027 fetch_count increments by 1 exactly on each REQ-021 load; holds at 32'hFFFF_FFFF.

Reset
REQ-028 reset=1 at a rising edge: pc=RESET_PC, ifid_instr=0, ifid_pc=0, ifid_valid=0, fault=0, fetch_count=0, state=BOOT.
REQ-029 reset overrides all inputs in every state, including mid-stall and FAULT.

Structure
REQ-030 Package fetch_pkg holds the state enum (BOOT=0, RUN=1, DONE=2, FAULT=3) and constant PC_STEP=4.
REQ-031 IF/ID register is a sub-module ifid_reg (enable, flush, 32-bit instr, 64-bit pc, valid).
REQ-032 No combinational path from stall or branch_taken to pc; pc is registered.

Verification
REQ-033 Reset, then 4 cycles no stall, instr_in=pc-derived -> BOOT 1 cycle; ifid_pc 0,4,8; pc=12; fetch_count=3.
REQ-034 Stall asserted 3 cycles at pc=8 -> pc, ifid_pc=4, ifid_valid=1 held 3 cycles; fetch_count unchanged.
REQ-035 stall=1 and branch_taken=1 target 0x40 same cycle -> pc=0x40, ifid_valid=0 next cycle, then ifid_pc=0x40.
REQ-036 Run from 0 with IMEM_BYTES=16 -> ifid_pc 0..12 valid, then DONE with pc=16; branch to 0x8 -> RUN, ifid_pc=8.
REQ-037 branch_target=0x42 -> fault=1, FAULT, pc held; further branches ignored; reset -> pc=0, fault=0, BOOT.
REQ-038 reset asserted mid-stream at pc=0x20 -> next cycle all outputs at REQ-028 values.
